// File: rtl/msrv32_pkg.sv
// Shared types for the msrv32 data-memory arbiter.
// FSM state, owner encoding and default watchdog limit.
package msrv32_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    BUSY_CORE = 2'b01,
    BUSY_DMA  = 2'b10
  } arb_state_e;

  typedef enum logic {
    CORE = 1'b0,
    DMA  = 1'b1
  } owner_e;

  localparam int unsigned TIMEOUT_DEF = 255;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  mask;
  } mem_req_t;

endpackage

// File: rtl/msrv32_rr_arb2.sv
// Two-way round-robin picker for the data-memory port.
// A tie goes to the side that was not granted last.
module msrv32_rr_arb2
  import msrv32_pkg::*;
(
  input  logic [1:0] req,
  input  owner_e     last_gnt,
  input  logic       exclude_valid,
  input  owner_e     exclude_id,
  output logic       gnt_valid,
  output owner_e     gnt_id
);

  logic [1:0] elig;

  always_comb begin
    elig = req;
    if (exclude_valid) begin
      if (exclude_id == DMA) elig[1] = 1'b0;
      else                   elig[0] = 1'b0;
    end
    gnt_valid = |elig;
    gnt_id    = CORE;
    unique case (1'b1)
      (elig == 2'b11): gnt_id = (last_gnt == CORE) ? DMA : CORE;
      (elig == 2'b10): gnt_id = DMA;
      (elig == 2'b01): gnt_id = CORE;
      default:         gnt_id = CORE;
    endcase
  end

endmodule

// File: rtl/msrv32_dmem_arbiter.sv
// Shares the msrv32 data-memory port between core and DMA master,
// with registered port outputs and a per-access watchdog.
module msrv32_dmem_arbiter
  import msrv32_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEF
) (
  input  logic        ms_riscv32_mp_clk_in,
  input  logic        ms_riscv32_mp_rst_n_in,
  input  logic        core_req_in,
  input  logic        core_we_in,
  input  logic [31:0] core_addr_in,
  input  logic [31:0] core_wdata_in,
  input  logic [3:0]  core_mask_in,
  output logic        core_ack_out,
  output logic        core_err_out,
  output logic        core_stall_out,
  output logic [31:0] core_rdata_out,
  input  logic        dma_req_in,
  input  logic        dma_we_in,
  input  logic [31:0] dma_addr_in,
  input  logic [31:0] dma_wdata_in,
  input  logic [3:0]  dma_mask_in,
  output logic        dma_ack_out,
  output logic        dma_err_out,
  output logic [31:0] dma_rdata_out,
  output logic [31:0] ms_riscv32_mp_dmaddr_out,
  output logic [31:0] ms_riscv32_mp_dmdata_out,
  output logic [3:0]  ms_riscv32_mp_dmwr_mask_out,
  output logic        ms_riscv32_mp_dmwr_req_out,
  output logic        ms_riscv32_mp_dmrd_req_out,
  input  logic [31:0] ms_riscv32_mp_dmdata_in,
  input  logic        ms_riscv32_mp_hready_in
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT_CYCLES);

  arb_state_e  state_q, state_d;
  owner_e      last_q, last_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic [3:0]  mask_q, mask_d;
  logic        wr_q, wr_d;
  logic        rd_q, rd_d;

  logic     busy, hit, tmo, done;
  owner_e   own;
  logic     gnt_valid;
  owner_e   gnt_id;
  mem_req_t core_r, dma_r, pick;

  assign busy = (state_q != IDLE);
  assign own  = (state_q == BUSY_DMA) ? DMA : CORE;
  assign hit  = busy & ms_riscv32_mp_hready_in;
  assign tmo  = busy & ~ms_riscv32_mp_hready_in & (cnt_q == TMAX);
  assign done = hit | tmo;

  assign core_r = '{core_we_in, core_addr_in, core_wdata_in, core_mask_in};
  assign dma_r  = '{dma_we_in, dma_addr_in, dma_wdata_in, dma_mask_in};
  assign pick   = (gnt_id == DMA) ? dma_r : core_r;

  // While busy the owner is masked so its still-high request
  // cannot be regranted at its own completion edge.
  msrv32_rr_arb2 u_arb (
    .req           ({dma_req_in, core_req_in}),
    .last_gnt      (last_q),
    .exclude_valid (busy),
    .exclude_id    (own),
    .gnt_valid     (gnt_valid),
    .gnt_id        (gnt_id)
  );

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    data_d  = data_q;
    mask_d  = mask_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    if (!busy || done) begin
      if (done) last_d = own;
      if (gnt_valid) begin
        state_d = (gnt_id == DMA) ? BUSY_DMA : BUSY_CORE;
        addr_d  = pick.addr & 32'hFFFF_FFFC;
        data_d  = pick.wdata;
        mask_d  = pick.we ? pick.mask : 4'b0000;
        wr_d    = pick.we;
        rd_d    = ~pick.we;
        cnt_d   = '0;
      end else begin
        state_d = IDLE;
        wr_d    = 1'b0;
        rd_d    = 1'b0;
      end
    end else if (!ms_riscv32_mp_hready_in && cnt_q != TMAX) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_n_in) begin
    if (!ms_riscv32_mp_rst_n_in) begin
      state_q <= IDLE;
      last_q  <= DMA;
      cnt_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      mask_q  <= '0;
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      mask_q  <= mask_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
    end
  end

  assign core_ack_out   = hit & (own == CORE);
  assign core_err_out   = tmo & (own == CORE);
  assign dma_ack_out    = hit & (own == DMA);
  assign dma_err_out    = tmo & (own == DMA);
  assign core_stall_out = core_req_in & ~core_ack_out;
  assign core_rdata_out = (core_ack_out & rd_q) ? ms_riscv32_mp_dmdata_in : 32'h0;
  assign dma_rdata_out  = (dma_ack_out & rd_q) ? ms_riscv32_mp_dmdata_in : 32'h0;

  assign ms_riscv32_mp_dmaddr_out    = addr_q;
  assign ms_riscv32_mp_dmdata_out    = data_q;
  assign ms_riscv32_mp_dmwr_mask_out = mask_q;
  assign ms_riscv32_mp_dmwr_req_out  = wr_q;
  assign ms_riscv32_mp_dmrd_req_out  = rd_q;

endmodule

// File: doc/msrv32_dmem_arbiter.md
# msrv32_dmem_arbiter

Sequential arbiter that shares the single data-memory port of the msrv32 core between two requesters: the core load/store path (store-unit outputs plus load requests) and a DMA/debug master. Each access is registered onto the memory port and held until the memory asserts `ms_riscv32_mp_hready_in`. A watchdog aborts accesses that never complete. The block sits between the core's store/load units and the top-level `ms_riscv32_mp_dm*` pins.

## Interface
- `TIMEOUT_CYCLES`, default 255: maximum wait cycles per access before abort; legal range 1..65535.
- `ms_riscv32_mp_clk_in  in  1`: clock, rising edge.
- `ms_riscv32_mp_rst_n_in  in  1`: reset, asynchronous, active-low.
- `core_req_in  in  1`: core access request; held with its payload until `core_ack_out`.
- `core_we_in  in  1`: 1 = write, 0 = read.
- `core_addr_in  in  32`: byte address.
- `core_wdata_in  in  32`: lane-aligned write data.
- `core_mask_in  in  4`: byte write mask.
- `core_ack_out  out  1`: access completed this cycle.
- `core_err_out  out  1`: access aborted by timeout this cycle.
- `core_stall_out  out  1`: `core_req_in & ~core_ack_out`.
- `core_rdata_out  out  32`: read data, valid while `core_ack_out` is high on a read.
- `dma_req_in`, `dma_we_in`, `dma_addr_in[31:0]`, `dma_wdata_in[31:0]`, `dma_mask_in[3:0]`  in: same semantics as the core inputs.
- `dma_ack_out`, `dma_err_out`  out  1: same semantics as the core outputs.
- `dma_rdata_out  out  32`: same semantics as `core_rdata_out`.
- `ms_riscv32_mp_dmaddr_out  out  32`: registered word address, `{addr[31:2],2'b00}`.
- `ms_riscv32_mp_dmdata_out  out  32`: registered write data.
- `ms_riscv32_mp_dmwr_mask_out  out  4`: registered mask; forced to 0 on reads.
- `ms_riscv32_mp_dmwr_req_out  out  1`: write strobe, high for the whole write access.
- `ms_riscv32_mp_dmrd_req_out  out  1`: read strobe, high for the whole read access.
- `ms_riscv32_mp_dmdata_in  in  32`: read data from memory.
- `ms_riscv32_mp_hready_in  in  1`: memory completes the current access this cycle.

## Operation
- FSM states: IDLE, BUSY_CORE, BUSY_DMA.
- IDLE: if any request is pending, a 2-way round-robin picks the owner.
  - The side not granted last wins a tie.
  - The `last_gnt` pointer resets to DMA, so the core wins the first tie.
  - At the edge, the winner's payload is latched into the memory-port registers, the wait counter is cleared, and the FSM enters BUSY_x.
- BUSY_x: memory outputs are stable from the registers; requester inputs are ignored.
- Completion happens in a BUSY cycle with `hready_in=1`.
  - The owner's `ack_out` is 1, driven combinationally.
  - For a read, the owner's `rdata_out` passes `dmdata_in` through.
  - `last_gnt` takes the owner.
- Back-to-back grant: at the completion edge, if the other requester is pending, it is granted immediately with no IDLE cycle. Otherwise the FSM goes to IDLE and the strobes drop.
  - The completing requester is excluded at that edge, because its request is still high during its ack cycle.
- Timeout: the wait counter increments each BUSY cycle with `hready_in=0`.
  - When the counter reaches `TIMEOUT_CYCLES`, the owner's `err_out` pulses instead of `ack_out`, and the access is abandoned.
  - Transition rules are the same as for completion.
- `rdata_out` of the non-owner, and of the owner when no read is completing, is 0.
- Requesters must hold request and payload stable until ack or err. Changing them earlier is a protocol violation, and the bench flags it with an assertion.

## Timing
- Reset: FSM = IDLE, `last_gnt` = DMA, counter = 0. All outputs are 0: address, data, mask, both strobes, both acks, both errs, both rdata.
- Reset mid-access drops the strobes asynchronously; the pending access is lost and the requester reissues it.
- Grant latency: request seen in IDLE at edge N puts the strobe on the memory pins after edge N.
- Zero-wait memory: ack in cycle N+1, so each access takes 2 cycles from IDLE.
- Back-to-back alternation from the other requester adds 0 extra cycles; the strobes stay high across the boundary.
- Same requester reissuing after its own ack: the request is seen at the next edge, so there is 1 IDLE cycle unless the other side is pending.
- `hready_in` and the timeout in the same cycle: completion wins, so ack is issued and no err.
- Counter width is `$clog2(TIMEOUT_CYCLES+1)`, saturating; it never wraps.

## Structure
- Shared package `msrv32_pkg` holds:
  - the state enum: IDLE=2'b00, BUSY_CORE=2'b01, BUSY_DMA=2'b10;
  - the owner encoding: CORE=1'b0, DMA=1'b1;
  - the default `TIMEOUT_CYCLES`.
- Sub-module `msrv32_rr_arb2` is a combinational 2-way round-robin picker. Inputs: `req[1:0]`, `last_gnt`, `exclude_valid`, `exclude_id`. Outputs: `gnt_valid`, `gnt_id`.

## Test plan
- Core write to addr 0x103, wdata 0x0000_AB00, mask 4'b0010, hready always 1 -> `dmaddr_out` = 0x100, `dmwr_req_out` = 1 for 1 cycle, `core_ack_out` in the 2nd cycle, `core_stall_out` = 1 only in cycle 1.
- Both requests asserted together from reset -> core granted first, DMA granted at the core's completion edge, strobes continuous, acks 1 cycle apart.
- DMA read from 0x40, hready held low 3 cycles, `dmdata_in` = 0xDEADBEEF -> `dma_ack_out` and `dma_rdata_out` = 0xDEADBEEF in the 4th BUSY cycle; `dmwr_mask_out` = 0.
- `TIMEOUT_CYCLES` = 4, hready never asserted -> `core_err_out` pulses after 4 wait cycles, no ack, FSM returns to IDLE.
- Both requesters continuously requesting for 20 accesses -> grants strictly alternate core, DMA, core, and so on.
- Reset asserted during BUSY_DMA with hready low -> all outputs 0 immediately; after release, a pending core request is granted first.
